// File: rtl/phase_accum_dco.sv
// Phase-accumulator DCO: the frequency word is steered by a clamped control value and only updated on wraps.
// Optional build macro DCO_DITHER_EN adds LFSR dithering of the frequency word LSB.
module phase_accum_dco #(
  parameter int unsigned          ACC_WIDTH  = 24,
  parameter logic [ACC_WIDTH-1:0] BASE_FCW   = 24'h100000,
  parameter int unsigned          GAIN_SHIFT = 4,
  parameter logic [19:0]          CTRL_MAX   = 20'hF0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [19:0]          dig_ctrl_voltage,
  input  logic                 enable,
  output logic                 dco_out,
  output logic                 dco_tick,
  output logic [ACC_WIDTH-1:0] fcw_active,
  output logic                 ctrl_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ACC_WIDTH:0] FCW_LIMIT = {2'b00, {(ACC_WIDTH-1){1'b1}}};

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH:0]   fcw_sum;
  logic [ACC_WIDTH-1:0] fcw_next;
  logic [19:0]          ctrl_q;
  logic [19:0]          ctrl_c;
  logic                 wrap;
  logic                 fcw_load;
  logic                 dither;

  function automatic logic [ACC_WIDTH-1:0] sat_fcw(input logic [ACC_WIDTH:0] sum);
    if (sum > FCW_LIMIT) return FCW_LIMIT[ACC_WIDTH-1:0];
    return sum[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [19:0] clamp_ctrl(input logic [19:0] val);
    return (val > CTRL_MAX) ? CTRL_MAX : val;
  endfunction

`ifdef DCO_DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; steps once per oscillator period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (wrap) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif

  assign ctrl_c   = clamp_ctrl(ctrl_q);
  assign fcw_sum  = {1'b0, BASE_FCW}
                  + (ACC_WIDTH+1)'(ctrl_c >> GAIN_SHIFT)
                  + (ACC_WIDTH+1)'(dither);
  assign fcw_next = sat_fcw(fcw_sum);

  assign acc_sum  = {1'b0, acc} + {1'b0, fcw_active};
  assign wrap     = (state != IDLE) && acc_sum[ACC_WIDTH];
  // The frequency word may only move while stopped or at a period boundary
  assign fcw_load = (state == IDLE) || wrap;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        acc_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        acc_nxt = acc_sum[ACC_WIDTH-1:0];
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        acc_nxt = acc_sum[ACC_WIDTH-1:0];
        if (enable) begin
          state_nxt = RUN;
        end else if (wrap) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      ctrl_q     <= '0;
      ctrl_sat   <= 1'b0;
      fcw_active <= BASE_FCW;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      ctrl_q   <= dig_ctrl_voltage;
      ctrl_sat <= (ctrl_q > CTRL_MAX);
      if (fcw_load) fcw_active <= fcw_next;
    end
  end

  assign dco_out  = acc[ACC_WIDTH-1];
  assign dco_tick = wrap;

endmodule

// File: tb/tb_phase_accum_dco.sv
// Directed bench for phase_accum_dco with a cycle-level reference model and per-cycle output comparison.
module tb_phase_accum_dco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [19:0] ctrl;
  logic        dco_out;
  logic        dco_tick;
  logic [23:0] fcw_active;
  logic        ctrl_sat;

  int checks = 0;
  int errors = 0;

  phase_accum_dco dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dig_ctrl_voltage (ctrl),
    .enable           (enable),
    .dco_out          (dco_out),
    .dco_tick         (dco_tick),
    .fcw_active       (fcw_active),
    .ctrl_sat         (ctrl_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: phase as a plain integer modulo 2^24; mode 0 stopped, 1 running, 2 finishing last period
  localparam longint MOD  = 64'h1000000;
  localparam longint HALF = 64'h800000;

  longint      m_acc, m_fcw;
  int          m_mode;
  logic [19:0] m_ctrl;
  logic        m_sat;
  logic        m_wrap;

  function automatic longint fcw_rule(input logic [19:0] c);
    longint v;
    v = longint'(c);
    if (v > 64'hF0000) v = 64'hF0000;
    v = 64'h100000 + v / 16;
    if (v > 64'h7FFFFF) v = 64'h7FFFFF;
    return v;
  endfunction

  assign m_wrap = (m_mode != 0) && (m_acc + m_fcw >= MOD);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  <= 0;
      m_fcw  <= 64'h100000;
      m_mode <= 0;
      m_ctrl <= '0;
      m_sat  <= 1'b0;
    end else begin
      m_ctrl <= ctrl;
      m_sat  <= (m_ctrl > 20'hF0000);
      if (m_mode == 0) begin
        m_fcw <= fcw_rule(m_ctrl);
        m_acc <= 0;
        if (enable) m_mode <= 1;
      end else begin
        m_acc <= (m_acc + m_fcw) % MOD;
        if (m_wrap) m_fcw <= fcw_rule(m_ctrl);
        if (enable) m_mode <= 1;
        else if (m_mode == 2 && m_wrap) begin
          m_mode <= 0;
          m_acc  <= 0;
        end else m_mode <= 2;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_dco_out", 32'(dco_out), 32'(m_acc >= HALF));
    check("cmp_dco_tick", 32'(dco_tick), 32'(m_wrap));
    check("cmp_fcw_active", 32'(fcw_active), 32'(m_fcw));
    check("cmp_ctrl_sat", 32'(ctrl_sat), 32'(m_sat));
  end

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dco_tick && n < budget);
  endtask

  task automatic measure(output int per, output int hi);
    per = 0;
    hi  = 0;
    do begin
      @(negedge clk);
      per++;
      if (dco_out) hi++;
    end while (!dco_tick && per < 64);
  endtask

  initial begin
    int w, per, hi, tk;
    rst_n  = 1'b0;
    enable = 1'b0;
    ctrl   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dco_out", 32'(dco_out), 32'd0);
    check("reset_dco_tick", 32'(dco_tick), 32'd0);
    check("reset_ctrl_sat", 32'(ctrl_sat), 32'd0);
    check("reset_fcw", 32'(fcw_active), 32'h100000);
    #2 rst_n = 1'b1;

    // Free-running at base frequency
    @(negedge clk);
    enable = 1'b1;
    wait_tick(64, w);
    check("first_tick_latency", 32'(w), 32'd16);
    measure(per, hi);
    check("base_period", 32'(per), 32'd16);
    check("base_high_cycles", 32'(hi), 32'd8);

    // Over-range control: saturation flag and clamped frequency word
    @(negedge clk);
    ctrl = 20'hFFFFF;
    @(negedge clk);
    check("sat_after_1", 32'(ctrl_sat), 32'd0);
    @(negedge clk);
    check("sat_after_2", 32'(ctrl_sat), 32'd1);
    wait_tick(64, w);
    check("sat_tick_wait", 32'(w), 32'd13);
    check("sat_fcw_before_wrap", 32'(fcw_active), 32'h100000);
    @(negedge clk);
    check("sat_fcw_after_wrap", 32'(fcw_active), 32'h10F000);

    // Mid-period control change is held off until the wrap
    ctrl = 20'h0;
    wait_tick(64, w);
    check("back_to_base_tick", 32'(dco_tick), 32'd1);
    @(negedge clk);
    check("back_to_base_fcw", 32'(fcw_active), 32'h100000);
    repeat (2) @(negedge clk);
    ctrl = 20'h80000;
    wait_tick(64, w);
    check("mid_change_tick_wait", 32'(w), 32'd13);
    check("mid_change_fcw_held", 32'(fcw_active), 32'h100000);
    @(negedge clk);
    check("mid_change_fcw_new", 32'(fcw_active), 32'h108000);

    // Stop request at cycle 5: one more tick, then idle
    ctrl = 20'h0;
    wait_tick(64, w);
    check("stop_prep_tick", 32'(dco_tick), 32'd1);
    @(negedge clk);
    check("stop_prep_fcw", 32'(fcw_active), 32'h100000);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    wait_tick(64, w);
    check("drain_tick_wait", 32'(w), 32'd11);
    tk = 0;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (dco_tick) tk++;
      if (dco_out) hi++;
    end
    check("idle_no_ticks", 32'(tk), 32'd0);
    check("idle_out_low", 32'(hi), 32'd0);
    check("idle_fcw", 32'(fcw_active), 32'h100000);
    enable = 1'b1;
    wait_tick(64, w);
    check("restart_latency", 32'(w), 32'd16);

    // Stop cancelled at cycle 10: period unaffected
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_tick(64, w);
    check("cancel_tick_wait", 32'(w), 32'd6);
    measure(per, hi);
    check("cancel_period", 32'(per), 32'd16);
    check("cancel_high_cycles", 32'(hi), 32'd8);

    // Enable falls on the wrap cycle: wrap taken, one more period drains
    enable = 1'b0;
    wait_tick(64, w);
    check("wrap_fall_drain_wait", 32'(w), 32'd16);
    repeat (3) @(negedge clk);
    check("wrap_fall_idle_out", 32'(dco_out), 32'd0);
    enable = 1'b1;
    wait_tick(64, w);
    check("wrap_fall_restart", 32'(w), 32'd16);

    // Reset in the high half of a period
    repeat (10) @(negedge clk);
    check("pre_reset_out_high", 32'(dco_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(dco_out), 32'd0);
    check("async_reset_tick", 32'(dco_tick), 32'd0);
    check("async_reset_fcw", 32'(fcw_active), 32'h100000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_tick(64, w);
    check("post_reset_latency", 32'(w), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
